// File: rtl/ramb_sdp_stream.sv
// Simple-dual-port block RAM with byte-lane write enables and a
// credit-tracked, flow-controlled read response stream.
//
// Ports:
//   clk        rising-edge clock for all logic
//   aresetn    asynchronous active-low reset (memory contents kept)
//   wr_en      write strobe
//   wr_be      per-lane write enables, lane i = wr_data[i*BWIDTH +: BWIDTH]
//   wr_addr    write address (addresses >= DEPTH are ignored)
//   wr_data    write data
//   rd_addr    read request address (addresses >= DEPTH read as 0)
//   rd_valid   read request valid
//   rd_ready   read request accepted when rd_valid & rd_ready
//   rdq_data   read response data (head of response queue)
//   rdq_valid  read response valid
//   rdq_ready  response consumed when rdq_valid & rdq_ready

module ramb_sdp_stream #(
    parameter int DWIDTH    = 36,
    parameter int BWIDTH    = 9,
    parameter int AWIDTH    = 10,
    parameter int DEPTH     = 2**AWIDTH,
    parameter int RD_LAT    = 1,
    parameter     MEM_INIT  = "",
    parameter     RAM_STYLE = "auto"
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     wr_en,
    input  logic [DWIDTH/BWIDTH-1:0] wr_be,
    input  logic [AWIDTH-1:0]        wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic [AWIDTH-1:0]        rd_addr,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    output logic [DWIDTH-1:0]        rdq_data,
    output logic                     rdq_valid,
    input  logic                     rdq_ready
);

    localparam int NBE = DWIDTH / BWIDTH;
    localparam int L   = 1 + RD_LAT;
    localparam int F   = L + 1;
    localparam int CW  = $clog2(F + 1);
    // Skid buffer behind the output head register; head + skid hold F.
    localparam int BD  = F - 1;
    localparam int PW  = $clog2(BD);
    localparam int BCW = $clog2(BD + 1);

    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

    (* ram_style = RAM_STYLE *)
    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    logic accept;
    logic pop;
    logic wr_hit;
    logic rd_hit;

    assign accept = rd_valid & rd_ready;
    assign pop    = rdq_valid & rdq_ready;
    assign wr_hit = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_hit = ({1'b0, rd_addr} < DEPTH_W);

    // ------------------------------------------------------------------
    // Write port. Blocked while reset is held; memory is never cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && aresetn && wr_hit) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BWIDTH +: BWIDTH] <=
                        wr_data[i*BWIDTH +: BWIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit counter. rd_ready is a register so it has no combinational
    // path from rd_valid or rdq_ready, and stays low during reset.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (accept && !pop) begin
            cnt_next = cnt + 1'b1;
        end else if (!accept && pop) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt      <= '0;
            rd_ready <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            rd_ready <= (cnt_next < CW'(F));
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 is the RAM read register (read-first: the
    // write above lands in the same edge, so the old word is captured).
    // The output head register is the final pipeline stage.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0]             p_valid;
    logic [RD_LAT-1:0][DWIDTH-1:0] p_data;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            p_valid <= '0;
        end else begin
            p_valid <= RD_LAT'({p_valid, accept});
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p_data[0] <= rd_hit ? mem[rd_addr] : '0;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            p_data[k] <= p_data[k-1];
        end
    end

    logic              in_valid;
    logic [DWIDTH-1:0] in_data;

    assign in_valid = p_valid[RD_LAT-1];
    assign in_data  = p_data[RD_LAT-1];

    // ------------------------------------------------------------------
    // Response queue: registered head (FWFT) plus a small skid buffer.
    // The head refills from the skid first to keep request order, and
    // only bypasses the skid when it is empty.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] skid_mem [BD];
    logic [PW-1:0]     skid_wp;
    logic [PW-1:0]     skid_rp;
    logic [BCW-1:0]    skid_cnt;
    logic              skid_empty;
    logic              head_load;
    logic              skid_push;
    logic              skid_pop;

    assign skid_empty = (skid_cnt == '0);
    assign head_load  = ~rdq_valid | pop;
    assign skid_pop   = head_load & ~skid_empty;
    assign skid_push  = in_valid & ~(head_load & skid_empty);

    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_mem[skid_wp] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            skid_wp  <= '0;
            skid_rp  <= '0;
            skid_cnt <= '0;
        end else begin
            if (skid_push) begin
                skid_wp <= (skid_wp == PW'(BD - 1)) ? '0 : skid_wp + 1'b1;
            end
            if (skid_pop) begin
                skid_rp <= (skid_rp == PW'(BD - 1)) ? '0 : skid_rp + 1'b1;
            end
            if (skid_push && !skid_pop) begin
                skid_cnt <= skid_cnt + 1'b1;
            end else if (!skid_push && skid_pop) begin
                skid_cnt <= skid_cnt - 1'b1;
            end
        end
    end

    // Head data is only reloaded with a real word, so it holds the last
    // delivered value while rdq_valid is low.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rdq_valid <= 1'b0;
            rdq_data  <= '0;
        end else if (head_load) begin
            if (!skid_empty) begin
                rdq_valid <= 1'b1;
                rdq_data  <= skid_mem[skid_rp];
            end else if (in_valid) begin
                rdq_valid <= 1'b1;
                rdq_data  <= in_data;
            end else begin
                rdq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ramb_sdp_stream.sv
// Directed testbench for ramb_sdp_stream (RD_LAT=1, DEPTH=1000).
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_ramb_sdp_stream;

    localparam int DW  = 36;
    localparam int AW  = 10;
    localparam int NBE = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          wr_en;
    logic [NBE-1:0] wr_be;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rdq_data;
    logic          rdq_valid;
    logic          rdq_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ramb_sdp_stream #(
        .DWIDTH (DW),
        .BWIDTH (9),
        .AWIDTH (AW),
        .DEPTH  (1000),
        .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .wr_en     (wr_en),
        .wr_be     (wr_be),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rdq_data  (rdq_data),
        .rdq_valid (rdq_valid),
        .rdq_ready (rdq_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NBE-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                      output bit got);
        got = 1'b0; d = '0;
        rdq_ready = 1'b1; rd_addr = a; rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (rdq_valid) begin
                got = 1'b1;
                d = rdq_data;
            end
            step();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; wr_en = 1'b0; wr_be = '0; wr_addr = '0;
        wr_data = '0; rd_addr = '0; rd_valid = 1'b0; rdq_ready = 1'b0;
        step(); step();
        n_cmp++; if (rd_ready !== 1'b0) begin n_err++;
            $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        n_cmp++; if (rdq_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_rdq_valid: got %b want 0", rdq_valid); end
        n_cmp++; if (rdq_data !== '0) begin n_err++;
            $display("FAIL reset_rdq_data: got %h want 0", rdq_data); end
        aresetn = 1'b1;
        #1;
        n_cmp++; if (rd_ready !== 1'b0) begin n_err++;
            $display("FAIL release_same_cycle: got %b want 0", rd_ready); end
        step();
        n_cmp++; if (rd_ready !== 1'b1) begin n_err++;
            $display("FAIL release_next_cycle: got %b want 1", rd_ready); end
    endtask

    task automatic test_stream();
        int beats, bad, bubbles, stalls;
        bit started;
        for (int i = 0; i < 100; i++) wr(AW'(i), DW'(i), '1);
        rdq_ready = 1'b1; rd_addr = 10'd5; rd_valid = 1'b1;
        n_cmp++; if (rd_ready !== 1'b1) begin n_err++;
            $display("FAIL lat_ready: got %b want 1", rd_ready); end
        step();
        rd_valid = 1'b0;
        n_cmp++; if (rdq_valid !== 1'b0) begin n_err++;
            $display("FAIL lat_c1_valid: got %b want 0", rdq_valid); end
        step();
        n_cmp++; if (rdq_valid !== 1'b1 || rdq_data !== 36'd5) begin n_err++;
            $display("FAIL lat_c2: got v=%b d=%h want v=1 d=5",
                     rdq_valid, rdq_data); end
        step();
        n_cmp++; if (rdq_valid !== 1'b0) begin n_err++;
            $display("FAIL lat_drain: got %b want 0", rdq_valid); end
        beats = 0; bad = 0; bubbles = 0; stalls = 0; started = 1'b0;
        for (int cyc = 0; cyc < 110; cyc++) begin
            if (cyc < 100) begin
                rd_valid = 1'b1; rd_addr = AW'(cyc);
                if (!rd_ready) stalls++;
            end else begin
                rd_valid = 1'b0;
            end
            if (rdq_valid) begin
                if (rdq_data !== DW'(beats)) bad++;
                beats++;
                started = 1'b1;
            end else if (started && beats < 100) begin
                bubbles++;
            end
            step();
        end
        n_cmp++; if (beats != 100) begin n_err++;
            $display("FAIL b2b_beats: got %0d want 100", beats); end
        n_cmp++; if (bad != 0) begin n_err++;
            $display("FAIL b2b_data: got %0d bad want 0", bad); end
        n_cmp++; if (bubbles != 0 || stalls != 0) begin n_err++;
            $display("FAIL b2b_bubbles: got %0d/%0d want 0/0",
                     bubbles, stalls); end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] d;
        bit got;
        wr(10'd7, 36'h0_0000_0000, 4'b1111);
        wr(10'd7, 36'hF_FFFF_FFFF, 4'b0101);
        rd(10'd7, d, got);
        n_cmp++; if (!got || d !== 36'h0_07FC_01FF) begin n_err++;
            $display("FAIL be_0101: got %b/%h want 1/007fc01ff", got, d); end
        wr(10'd7, 36'h1_2345_6789, 4'b0000);
        rd(10'd7, d, got);
        n_cmp++; if (!got || d !== 36'h0_07FC_01FF) begin n_err++;
            $display("FAIL be_none: got %b/%h want 1/007fc01ff", got, d); end
        wr(10'd7, 36'hF_FFFF_FFFF, 4'b1000);
        rd(10'd7, d, got);
        n_cmp++; if (!got || d !== 36'hF_FFFC_01FF) begin n_err++;
            $display("FAIL be_1000: got %b/%h want 1/ffffc01ff", got, d); end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        bit got;
        wr(10'd999, 36'h123, '1);
        wr(10'd1000, 36'h456, '1);
        wr(10'd1023, 36'h789, '1);
        rd(10'd999, d, got);
        n_cmp++; if (!got || d !== 36'h123) begin n_err++;
            $display("FAIL oor_last: got %b/%h want 1/123", got, d); end
        rd(10'd1000, d, got);
        n_cmp++; if (!got || d !== '0) begin n_err++;
            $display("FAIL oor_1000: got %b/%h want 1/0", got, d); end
        rd(10'd1023, d, got);
        n_cmp++; if (!got || d !== '0) begin n_err++;
            $display("FAIL oor_1023: got %b/%h want 1/0", got, d); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q[$];
        logic [DW-1:0] e;
        int acc, nxt, got_n, dup;
        acc = 0; nxt = 10; got_n = 0; dup = 0;
        rdq_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            rd_valid = 1'b1; rd_addr = AW'(nxt);
            if (rd_ready) begin
                q.push_back(DW'(nxt)); nxt++; acc++;
            end
            step();
        end
        rd_valid = 1'b0;
        n_cmp++; if (acc != 3 || rd_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_accepts: got %0d rdy=%b want 3 rdy=0",
                     acc, rd_ready); end
        n_cmp++; if (rdq_valid !== 1'b1 || rdq_data !== 36'd10) begin n_err++;
            $display("FAIL bp_head: got v=%b d=%h want v=1 d=a",
                     rdq_valid, rdq_data); end
        step(); step();
        n_cmp++; if (rdq_valid !== 1'b1 || rdq_data !== 36'd10) begin n_err++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a",
                     rdq_valid, rdq_data); end
        for (int cyc = 0; cyc < 400 && (nxt < 30 || q.size() > 0); cyc++) begin
            rdq_ready = 1'($urandom_range(0, 1));
            rd_valid = (nxt < 30);
            rd_addr = AW'(nxt);
            if (rdq_valid && rdq_ready) begin
                if (q.size() == 0) begin
                    dup++;
                end else begin
                    e = q.pop_front();
                    got_n++;
                    n_cmp++; if (rdq_data !== e) begin n_err++;
                        $display("FAIL bp_order: got %h want %h",
                                 rdq_data, e); end
                end
            end
            if (rd_valid && rd_ready) begin
                q.push_back(DW'(nxt)); nxt++;
            end
            step();
        end
        rd_valid = 1'b0; rdq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rdq_valid) dup++;
            step();
        end
        n_cmp++; if (got_n != 20 || nxt != 30) begin n_err++;
            $display("FAIL bp_count: got %0d/%0d want 20/30", got_n, nxt); end
        n_cmp++; if (dup != 0) begin n_err++;
            $display("FAIL bp_dup: got %0d extra want 0", dup); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] beat [2];
        int n;
        n = 0; beat[0] = '0; beat[1] = '0;
        rdq_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 36'hABC; wr_be = '1;
        rd_valid = 1'b1; rd_addr = 10'd3;
        step();
        wr_en = 1'b0; wr_be = '0;
        step();
        rd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rdq_valid) begin
                if (n < 2) beat[n] = rdq_data;
                n++;
            end
            step();
        end
        n_cmp++; if (n != 2) begin n_err++;
            $display("FAIL col_beats: got %0d want 2", n); end
        n_cmp++; if (beat[0] !== 36'd3) begin n_err++;
            $display("FAIL col_old: got %h want 3", beat[0]); end
        n_cmp++; if (beat[1] !== 36'hABC) begin n_err++;
            $display("FAIL col_new: got %h want abc", beat[1]); end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] d;
        bit got;
        int seen;
        seen = 0;
        rdq_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 10'd20;
        step();
        rd_addr = 10'd21;
        step();
        rd_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        n_cmp++; if (rdq_valid !== 1'b0 || rd_ready !== 1'b0) begin n_err++;
            $display("FAIL mid_async: got v=%b r=%b want 0/0",
                     rdq_valid, rd_ready); end
        wr_en = 1'b1; wr_addr = 10'd50; wr_data = 36'hDEAD; wr_be = '1;
        step();
        wr_en = 1'b0; wr_be = '0;
        step();
        aresetn = 1'b1; rdq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rdq_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++;
            $display("FAIL mid_stale: got %0d beats want 0", seen); end
        rd(10'd42, d, got);
        n_cmp++; if (!got || d !== 36'd42) begin n_err++;
            $display("FAIL mid_new: got %b/%h want 1/2a", got, d); end
        rd(10'd50, d, got);
        n_cmp++; if (!got || d !== 36'd50) begin n_err++;
            $display("FAIL mid_wr_blocked: got %b/%h want 1/32", got, d); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_byte_enable();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
